// File: rtl/rr_sel3_scheduler_pkg.sv
// Shared encodings for the 3-source round-robin scheduler and its channel picker.
package rr_sel3_scheduler_pkg;

   localparam logic [1:0] SEL_I0 = 2'b00;
   localparam logic [1:0] SEL_I1 = 2'b01;
   localparam logic [1:0] SEL_I2 = 2'b10;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam int DWELL_DEFAULT = 4;
   localparam int CW_DEFAULT    = 8;

   // Next channel in the 0 -> 1 -> 2 -> 0 ring; an illegal 11 folds back to channel 0.
   function automatic logic [1:0] rr_inc3(input logic [1:0] c);
      return (c >= 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

   function automatic logic [2:0] sel_onehot(input logic [1:0] s);
      logic [2:0] oh;
      oh = 3'b000;
      case (s)
         SEL_I0:  oh = 3'b001;
         SEL_I1:  oh = 3'b010;
         SEL_I2:  oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rr_sel3_scheduler_pick.sv
// Combinational round-robin picker: scans last+1, last+2, last, optionally skipping one channel.
module rr_pick3
   import rr_sel3_scheduler_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   input  logic       exclude_en,
   input  logic [1:0] exclude,
   output logic [1:0] next,
   output logic       found
);

   logic [1:0] cand [3];
   logic [2:0] ok;

   always_comb begin
      cand[0] = rr_inc3(last);
      cand[1] = rr_inc3(cand[0]);
      cand[2] = (last > 2'd2) ? 2'd2 : last;
      for (int i = 0; i < 3; i++) begin
         ok[i] = req[cand[i]] && !(exclude_en && (cand[i] == exclude));
      end
   end

   always_comb begin
      next  = cand[2];
      found = 1'b0;
      if (ok[0]) begin
         next  = cand[0];
         found = 1'b1;
      end else if (ok[1]) begin
         next  = cand[1];
         found = 1'b1;
      end else if (ok[2]) begin
         next  = cand[2];
         found = 1'b1;
      end
   end

endmodule

// File: rtl/rr_sel3_scheduler.sv
// Round-robin scheduler driving the select of a 3:1 mux, with a bounded dwell per grant.
// valid=1 means sel/gnt name the current grantee for that whole cycle; there is no ready,
// the grantee gives the slot back with done (only looked at while valid=1).
module rr_sel3_scheduler
   import rr_sel3_scheduler_pkg::*;
#(
   parameter int DWELL = DWELL_DEFAULT,
   parameter int CW    = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [2:0]    req,
   input  logic          done,
   output logic [1:0]    sel,
   output logic [2:0]    gnt,
   output logic          valid,
   output logic [0:0]    dbg_state,
   output logic [CW-1:0] dbg_count
);

   logic [0:0]    state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic [2:0]    gnt_q;

   logic          cur_req;
   logic          timeout;
   logic          rel;
   logic [1:0]    pick_next;
   logic          pick_found;

   always_comb begin
      case (sel_q)
         SEL_I0:  cur_req = req[0];
         SEL_I1:  cur_req = req[1];
         SEL_I2:  cur_req = req[2];
         default: cur_req = 1'b0;
      endcase
   end

   assign timeout = (cnt_q == CW'(DWELL - 1));
   assign rel     = !en || done || !cur_req || timeout;

   // In GRANT the picker skips the current owner so a hand-off never lands on it again.
   rr_pick3 u_pick (
      .req        (req),
      .last       (last_q),
      .exclude_en (state_q == ST_GRANT),
      .exclude    (sel_q),
      .next       (pick_next),
      .found      (pick_found)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (en && pick_found) begin
               state_d = ST_GRANT;
               sel_d   = pick_next;
               last_d  = pick_next;
               cnt_d   = '0;
               valid_d = 1'b1;
            end
         end
         ST_GRANT: begin
            if (!rel) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!en) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (pick_found) begin
               sel_d   = pick_next;
               last_d  = pick_next;
               cnt_d   = '0;
               valid_d = 1'b1;
            end else if (timeout && !done && cur_req) begin
               // Sole requester hit the dwell limit: restart its dwell without a bubble.
               cnt_d   = '0;
               valid_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_I0;
         last_q  <= SEL_I2;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         gnt_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         gnt_q   <= valid_d ? sel_onehot(sel_d) : 3'b000;
      end
   end

   assign sel       = sel_q;
   assign gnt       = gnt_q;
   assign valid     = valid_q;
   assign dbg_state = state_q;
   assign dbg_count = cnt_q;

endmodule

// File: tb/tb_rr_sel3_scheduler.sv
// Directed bench for rr_sel3_scheduler: main instance at DWELL=4, second instance at DWELL=3.
module tb_rr_sel3_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] req = 3'b000;
   logic       done = 1'b0;

   logic [1:0] sel, sel3;
   logic [2:0] gnt, gnt3;
   logic       valid, valid3;
   logic [0:0] st, st3;
   logic [7:0] cnt, cnt3;

   int total = 0;
   int bad = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   rr_sel3_scheduler #(.DWELL(4), .CW(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
      .sel(sel), .gnt(gnt), .valid(valid), .dbg_state(st), .dbg_count(cnt)
   );

   rr_sel3_scheduler #(.DWELL(3), .CW(8)) u_dut3 (
      .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
      .sel(sel3), .gnt(gnt3), .valid(valid3), .dbg_state(st3), .dbg_count(cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] s, input logic [2:0] g,
                          input logic v);
      chk({tag, ".sel"}, 32'(sel), 32'(s));
      chk({tag, ".gnt"}, 32'(gnt), 32'(g));
      chk({tag, ".valid"}, 32'(valid), 32'(v));
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] rot_tab [15];
      logic [1:0] e;
      rot_tab = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                  2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};

      // 1: reset values and first grant
      #3;
      chk_out("rst", 2'b00, 3'b000, 1'b0);
      chk("rst.state", 32'(st), 32'd0);
      chk("rst.cnt", 32'(cnt), 32'd0);
      step();
      rst = 1'b0;
      en  = 1'b1;
      req = 3'b011;
      step();
      chk_out("first", 2'b00, 3'b001, 1'b1);
      chk("first.state", 32'(st), 32'd1);

      // 2: rotation with all three requesting, 4 cycles per grant
      req = 3'b111;
      for (int i = 0; i < 15; i++) exp_q.push_back(rot_tab[i]);
      for (int i = 1; i <= 15; i++) begin
         step();
         e = exp_q.pop_front();
         chk($sformatf("rot%0d.sel", i), 32'(sel), 32'(e));
         chk($sformatf("rot%0d.gnt", i), 32'(gnt), 32'(3'b001 << e));
         chk($sformatf("rot%0d.valid", i), 32'(valid), 32'd1);
         chk($sformatf("rot%0d.cnt", i), 32'(cnt), 32'(i % 4));
      end

      // 3: ch0 times out, ch1 granted, early done in its second cycle hands to ch2
      req = 3'b110;
      step();
      chk_out("early.g1", 2'b01, 3'b010, 1'b1);
      step();
      chk("early.cnt", 32'(cnt), 32'd1);
      done = 1'b1;
      step();
      done = 1'b0;
      chk_out("early.g2", 2'b10, 3'b100, 1'b1);
      chk("early.cnt0", 32'(cnt), 32'd0);

      // 4: sole requester ch2 on the DWELL=3 instance keeps the grant, counter wraps
      pulse_rst();
      req = 3'b100;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("sole%0d.sel", i), 32'(sel3), 32'(2'b10));
         chk($sformatf("sole%0d.gnt", i), 32'(gnt3), 32'(3'b100));
         chk($sformatf("sole%0d.valid", i), 32'(valid3), 32'd1);
         chk($sformatf("sole%0d.cnt", i), 32'(cnt3), 32'(i % 3));
      end

      // 5: requests drop -> idle with sel held; re-grant of ch0 after idle
      req = 3'b000;
      step();
      chk_out("drop2", 2'b10, 3'b000, 1'b0);
      chk("drop2.state", 32'(st), 32'd0);
      pulse_rst();
      req = 3'b001;
      step();
      chk_out("g0", 2'b00, 3'b001, 1'b1);
      req = 3'b000;
      step();
      chk_out("drop0", 2'b00, 3'b000, 1'b0);
      req = 3'b001;
      step();
      chk_out("regrant0", 2'b00, 3'b001, 1'b1);

      // en low forces release; next grant continues rotation from ch0
      req = 3'b111;
      en  = 1'b0;
      step();
      chk_out("en_off", 2'b00, 3'b000, 1'b0);
      step();
      chk_out("en_off_hold", 2'b00, 3'b000, 1'b0);
      en = 1'b1;
      step();
      chk_out("en_on", 2'b01, 3'b010, 1'b1);

      // 6: async reset between edges while ch1 holds the grant
      #2;
      rst = 1'b1;
      #1;
      chk_out("async", 2'b00, 3'b000, 1'b0);
      chk("async.cnt", 32'(cnt), 32'd0);
      #1;
      rst = 1'b0;
      req = 3'b111;
      step();
      chk_out("post_rst", 2'b00, 3'b001, 1'b1);

      // req change on a non-granted channel mid-grant has no effect
      req = 3'b101;
      step();
      chk_out("hold_mid", 2'b00, 3'b001, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
